// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the CPU and a UART debug request channel.
// The CPU has priority. A waiting UART request gets a one-cycle slot after MAX_CPU_BURST consecutive CPU cycles.
module data_mem_arbiter #(
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned MAX_CPU_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        uart_req_valid,
    output logic        uart_req_ready,
    input  logic        uart_req_rw,
    input  logic [8:0]  uart_req_addr,
    input  logic [31:0] uart_req_wdata,
    output logic        uart_rsp_valid,
    output logic [41:0] uart_rsp_data,
    input  logic        uart_rsp_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned ADDR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(MAX_CPU_BURST + 1);
    localparam int unsigned MASK_W    = (ADDR_BITS < 9) ? ADDR_BITS : 9;
    localparam logic [8:0]  ADDR_MASK = 9'((32'd1 << MASK_W) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CPU_BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACCESS, S_RSP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic             hold_rw;
    logic [8:0]       hold_addr;
    logic [31:0]      hold_wdata;
    logic [41:0]      rsp_data_q;
    logic             cpu_active;
    logic             uart_owns;
    logic [8:0]       eff_addr;

    assign cpu_active = cpu_mem_read | cpu_mem_write;
    assign uart_owns  = (state == S_ACCESS);
    // For memories smaller than the 9-bit UART address space, the address wraps.
    assign eff_addr   = hold_addr & ADDR_MASK;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            hold_rw    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            rsp_data_q <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            if (uart_req_valid && uart_req_ready) begin
                hold_rw    <= uart_req_rw;
                hold_addr  <= uart_req_addr;
                hold_wdata <= uart_req_wdata;
            end
            if (state == S_ACCESS && !hold_rw) begin
                rsp_data_q <= {1'b0, hold_addr, mem_rdata};
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            S_IDLE: begin
                starve_cnt_nxt = '0;
                if (uart_req_valid) state_nxt = S_PEND;
            end
            S_PEND: begin
                if (!cpu_active || starve_cnt == CNT_LAST) begin
                    state_nxt      = S_ACCESS;
                    starve_cnt_nxt = '0;
                end else begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end
            S_ACCESS: state_nxt = hold_rw ? S_IDLE : S_RSP;
            S_RSP:    if (uart_rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_mem_write;
        mem_read  = cpu_mem_read;
        cpu_stall = 1'b0;
        if (uart_owns) begin
            mem_addr  = {21'b0, eff_addr, 2'b00};
            mem_wdata = hold_wdata;
            mem_write = hold_rw;
            mem_read  = ~hold_rw;
            cpu_stall = cpu_active;
        end
    end

    assign cpu_rdata      = (!uart_owns && cpu_mem_read) ? mem_rdata : '0;
    assign uart_req_ready = (state == S_IDLE);
    assign uart_rsp_valid = (state == S_RSP);
    assign uart_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized checks of data_mem_arbiter against a transaction-level reference model.
// The reference model derives UART slot timing from the CPU activity pattern.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        uart_req_valid, uart_req_ready, uart_req_rw;
    logic [8:0]  uart_req_addr;
    logic [31:0] uart_req_wdata;
    logic        uart_rsp_valid, uart_rsp_ready;
    logic [41:0] uart_rsp_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(1024), .MAX_CPU_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .uart_req_valid(uart_req_valid), .uart_req_ready(uart_req_ready), .uart_req_rw(uart_req_rw),
        .uart_req_addr(uart_req_addr), .uart_req_wdata(uart_req_wdata),
        .uart_rsp_valid(uart_rsp_valid), .uart_rsp_data(uart_rsp_data), .uart_rsp_ready(uart_rsp_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    // Data memory with combinational read and a preload port.
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_val;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: CPU idle, 1: loads every cycle, 2: random loads/stores
    task automatic drive_cpu(input int mode, input bit act);
        cpu_mem_read  = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_addr      = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        cpu_wdata     = $urandom;
        if (act) begin
            if (mode == 1 || $urandom_range(0, 1) == 0) cpu_mem_read = 1'b1;
            else cpu_mem_write = 1'b1;
        end
    endtask

    task automatic check_cpu_side(input string tag, input bit owner_cpu, input bit stall_exp);
        chk({tag, "/stall"}, 64'(cpu_stall), 64'(stall_exp));
        if (owner_cpu) begin
            chk({tag, "/mem_addr"}, 64'(mem_addr), 64'(cpu_addr));
            chk({tag, "/mem_write"}, 64'(mem_write), 64'(cpu_mem_write));
            chk({tag, "/mem_read"}, 64'(mem_read), 64'(cpu_mem_read));
            chk({tag, "/cpu_rdata"}, 64'(cpu_rdata),
                cpu_mem_read ? 64'(ref_mem[cpu_addr[11:2]]) : 64'd0);
        end else begin
            chk({tag, "/cpu_rdata_blk"}, 64'(cpu_rdata), 64'd0);
        end
    endtask

    task automatic commit_cpu();
        if (cpu_mem_write) ref_mem[cpu_addr[11:2]] = cpu_wdata;
    endtask

    task automatic garbage_req();
        uart_req_valid = 1'($urandom);
        uart_req_rw    = 1'($urandom);
        uart_req_addr  = 9'($urandom);
        uart_req_wdata = $urandom;
    endtask

    task automatic run_txn(input bit rw, input logic [8:0] addr, input logic [31:0] wdata,
                           input int mode, input int delay, input bit abort);
        bit   act [0:8];
        int   npend;
        logic [41:0] exp_rsp;
        uart_req_valid = 1'b1;
        uart_req_rw    = rw;
        uart_req_addr  = addr;
        uart_req_wdata = wdata;
        uart_rsp_ready = 1'($urandom);
        drive_cpu(mode, mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1));
        #2;
        chk("accept/req_ready", 64'(uart_req_ready), 64'd1);
        chk("accept/rsp_valid", 64'(uart_rsp_valid), 64'd0);
        check_cpu_side("accept", 1'b1, 1'b0);
        commit_cpu();
        tick();
        // Slot comes after the first idle CPU cycle, or after 8 back-to-back CPU cycles.
        for (int i = 0; i < 9; i++)
            act[i] = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        npend = 8;
        for (int i = 0; i < 8; i++) begin
            if (!act[i]) begin
                npend = i + 1;
                break;
            end
        end
        for (int i = 0; i < npend; i++) begin
            garbage_req();
            drive_cpu(mode, act[i]);
            #2;
            chk("pend/req_ready", 64'(uart_req_ready), 64'd0);
            chk("pend/rsp_valid", 64'(uart_rsp_valid), 64'd0);
            check_cpu_side("pend", 1'b1, 1'b0);
            commit_cpu();
            tick();
        end
        garbage_req();
        drive_cpu(mode, act[npend]);
        #2;
        chk("access/req_ready", 64'(uart_req_ready), 64'd0);
        chk("access/rsp_valid", 64'(uart_rsp_valid), 64'd0);
        check_cpu_side("access", 1'b0, cpu_mem_read | cpu_mem_write);
        chk("access/mem_addr", 64'(mem_addr), 64'({21'b0, addr, 2'b00}));
        chk("access/mem_write", 64'(mem_write), 64'(rw));
        chk("access/mem_read", 64'(mem_read), 64'(!rw));
        if (rw) begin
            chk("access/mem_wdata", 64'(mem_wdata), 64'(wdata));
            ref_mem[{1'b0, addr}] = wdata;
        end
        exp_rsp = {1'b0, addr, ref_mem[{1'b0, addr}]};
        tick();
        if (!rw) begin
            for (int k = 0; k <= delay; k++) begin
                garbage_req();
                drive_cpu(mode, mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1));
                uart_rsp_ready = abort ? 1'b0 : (k == delay);
                #2;
                chk("rsp/rsp_valid", 64'(uart_rsp_valid), 64'd1);
                chk("rsp/rsp_data", 64'(uart_rsp_data), 64'(exp_rsp));
                chk("rsp/req_ready", 64'(uart_req_ready), 64'd0);
                check_cpu_side("rsp", 1'b1, 1'b0);
                if (abort) begin
                    cpu_mem_read   = 1'b0;
                    cpu_mem_write  = 1'b0;
                    uart_req_valid = 1'b0;
                    reset = 1'b0;
                    #1;
                    chk("abort/rsp_valid", 64'(uart_rsp_valid), 64'd0);
                    chk("abort/rsp_data", 64'(uart_rsp_data), 64'd0);
                    chk("abort/req_ready", 64'(uart_req_ready), 64'd1);
                    tick();
                    reset = 1'b1;
                    for (int j = 0; j < 3; j++) begin
                        uart_rsp_ready = 1'b1;
                        #2;
                        chk("post_abort/rsp_valid", 64'(uart_rsp_valid), 64'd0);
                        chk("post_abort/req_ready", 64'(uart_req_ready), 64'd1);
                        tick();
                    end
                    break;
                end
                commit_cpu();
                tick();
            end
        end
        uart_req_valid = 1'b0;
        uart_rsp_ready = 1'b0;
        cpu_mem_read   = 1'b0;
        cpu_mem_write  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        uart_req_valid = 1'b0; uart_req_rw = 1'b0; uart_req_addr = '0; uart_req_wdata = '0;
        uart_rsp_ready = 1'b0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        #2;
        chk("reset/req_ready", 64'(uart_req_ready), 64'd1);
        chk("reset/rsp_valid", 64'(uart_rsp_valid), 64'd0);
        chk("reset/rsp_data", 64'(uart_rsp_data), 64'd0);
        chk("reset/stall", 64'(cpu_stall), 64'd0);
        tick();
        for (int i = 0; i < 64; i++) begin
            pre_we  = 1'b1;
            pre_idx = 10'(i);
            pre_val = (i == 4) ? 32'h12345678 : $urandom;
            ref_mem[i] = pre_val;
            tick();
        end
        pre_we = 1'b0;
        reset  = 1'b1;
        #2;
        chk("release/req_ready", 64'(uart_req_ready), 64'd1);
        check_cpu_side("release", 1'b1, 1'b0);
        tick();

        // UART read with idle CPU: pend, access, response on consecutive cycles
        run_txn(1'b0, 9'h004, 32'h0, 0, 0, 1'b0);
        chk("uart_read/value", 64'(ref_mem[4]), 64'h12345678);

        // CPU-only store then load
        cpu_mem_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #2;
        chk("cpu_store/mem_write", 64'(mem_write), 64'd1);
        chk("cpu_store/stall", 64'(cpu_stall), 64'd0);
        commit_cpu();
        tick();
        cpu_mem_write = 1'b0; cpu_mem_read = 1'b1;
        #2;
        chk("cpu_load/mem_write", 64'(mem_write), 64'd0);
        chk("cpu_load/rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        chk("cpu_load/stall", 64'(cpu_stall), 64'd0);
        tick();
        cpu_mem_read = 1'b0;

        // Continuous CPU loads starve a UART write for exactly 8 cycles
        run_txn(1'b1, 9'h020, 32'hA5A5A5A5, 1, 0, 1'b0);
        #2;
        chk("starve/idle_after", 64'(uart_req_ready), 64'd1);
        tick();

        // Response backpressure for 5 cycles
        run_txn(1'b0, 9'h020, 32'h0, 2, 5, 1'b0);

        // Reset while a response is waiting
        run_txn(1'b0, 9'h011, 32'h0, 2, 0, 1'b1);

        for (int n = 0; n < 40; n++)
            run_txn(1'($urandom), 9'($urandom_range(0, 63)), $urandom, 2, $urandom_range(0, 4), 1'b0);

        #2;
        chk("final/req_ready", 64'(uart_req_ready), 64'd1);
        chk("final/rsp_valid", 64'(uart_rsp_valid), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
